pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Cycle-accurate hazard, stall and forwarding controller for the 5-stage DCPU pipeline.
- Sits beside the ID-stage instruction decoder and consumes its per-instruction decode signals.
- Keeps its own shadow scoreboard of the EX/MEM/WB destination registers.
- Drives stall, bubble, IF-squash and operand-forward selects; adds a multi-cycle multiplier busy counter.

Parameters:
REG_ADDR_W, 5, register address width
MUL_LATENCY, 3, EX-stage cycles occupied by MUL (>=1; 1 = single-cycle, never stalls)
WB_BYPASS, 1, 1 = regfile write-through (WB never hazards); 0 = WB destination also checked

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_rs  in  REG_ADDR_W  ID source register rs
id_rt  in  REG_ADDR_W  ID source register rt
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_waddr  in  REG_ADDR_W  ID destination register (after waddr mux)
id_write  in  1  ID instruction writes regfile
id_is_lw  in  1  ID instruction is LW
id_is_mul  in  1  ID instruction is MUL
id_is_jump  in  1  ID jump/branch taken (resolved in ID)
stall  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX
hold_ex  out  1  freeze ID/EX and EX contents (multiplier busy)
flush_if  out  1  squash instruction in IF/ID
fwd_rs_sel  out  2  00 regfile, 01 EX result, 10 MEM result
fwd_rt_sel  out  2  as fwd_rs_sel
mul_busy  out  1  multiplier occupying EX

Behaviour:
- Reset: clk and rst_n as stated; rst_n is asynchronous and active-low. All scoreboard entries cleared (write=0, waddr=0, lw=0, mul=0), counter=0. All outputs 0.
- Scoreboard: EX, MEM and WB slots, each holding {waddr, write, lw, mul}, advance on clk.
  - MEM<=EX and WB<=MEM every cycle unless hold_ex; under hold_ex, MEM<=bubble.
  - EX<=ID fields when !stall && !hold_ex; EX<=bubble when stall && !hold_ex; EX holds when hold_ex.
- Match rule: src matches slot iff uses_src && slot.write && slot.waddr==src && src!=0. Register 0 never hazards.
- Multiplier:
  - MUL entering EX with MUL_LATENCY>1 loads counter=MUL_LATENCY-1.
  - mul_busy = (counter!=0); hold_ex = mul_busy; stall = 1 while mul_busy.
  - Counter decrements each cycle to 0; the MUL leaves EX on the cycle after counter reaches 0.
  - A MUL immediately following a MUL reloads the counter on entry; no overlap.
- Hazard stall (combinational from ID inputs and scoreboard):
  - Without forwarding: stall if any source matches EX or MEM, or WB when WB_BYPASS=0.
  - bubble_ex = stall && !hold_ex.
- Jump: flush_if = id_is_jump && !stall. A jump seen while stalled is deferred until its operands are clean. Never flush and stall in the same cycle.
- Simultaneous events: mul_busy has priority. hold_ex=1, bubble_ex=0, stall=1, flush_if=0.
- fwd_*_sel is 00 whenever the macro below is absent.
- Async reset mid-MUL: counter and slots clear immediately; outputs 0 next evaluation.

Optional Feature:
HAZARD_FWD_EN
- Defined:
  - Stall only on load-use (src matches EX with lw=1) or MUL-use (src matches EX with mul=1 while mul_busy, or on the MUL's final EX cycle).
  - Otherwise fwd_*_sel = 01 on EX match, 10 on MEM match; EX has priority over MEM.
  - WB with WB_BYPASS=0 also stalls.
- Undefined: no forwarding. Select outputs tied to 00 and every RAW match stalls as above.

Test Plan:
- Reset: rst_n=0 mid-run -> all outputs 0 asynchronously; after release, first ADD $3,$1,$2 -> stall=0, fwd=00.
- No forwarding: ADD $1 then SUB $4,$1,$2 -> stall=1, bubble_ex=1 for 2 cycles; SUB issues 3rd cycle. Same test with rs=$0 -> no stall.
- HAZARD_FWD_EN: ADD $1 then OR $5,$1,$1 -> stall=0, fwd_rs_sel=fwd_rt_sel=01. One-instruction gap -> 10. LW $1 then use $1 -> exactly 1 stall cycle, then fwd=10.
- MUL_LATENCY=3: MUL $2 -> mul_busy=1, hold_ex=1, stall=1 for 2 cycles, MEM receives 2 bubbles. Back-to-back MUL -> counter reloads to 2.
- Jump: BEQ taken, no hazard -> flush_if=1 for 1 cycle. BEQ rs=$1 right after LW $1 -> flush_if=0 while stalled, flush_if=1 on the first clean cycle.
- WB_BYPASS=0, no forwarding: ADD $7 then 2 NOPs then use $7 -> 1 stall cycle (WB match).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, stall and forwarding controller for the 5-stage DCPU pipeline.
// It keeps a shadow scoreboard of the destination registers in EX, MEM and
// WB and compares them against the source registers of the instruction in
// ID. A down-counter models a multi-cycle multiplier occupying EX.
//
// Optional feature macro: HAZARD_FWD_EN
//   undefined : no forwarding, every RAW match stalls, fwd selects tied 00
//   defined   : EX/MEM forwarding, stall only on load-use / MUL-use
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_rs / id_rt         ID source registers
//   id_uses_rs/_rt        ID instruction actually reads rs / rt
//   id_waddr, id_write    ID destination register and write enable
//   id_is_lw, id_is_mul   ID instruction is a load / a multiply
//   id_is_jump            jump/branch taken, resolved in ID
//   stall                 hold PC and IF/ID
//   bubble_ex             load a NOP into ID/EX
//   hold_ex               freeze ID/EX and EX (multiplier busy)
//   flush_if              squash the instruction in IF/ID
//   fwd_rs_sel/_rt_sel    00 regfile, 01 EX result, 10 MEM result
//   mul_busy              multiplier still occupying EX
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 3,
    parameter int WB_BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_write,
    input  logic                  id_is_lw,
    input  logic                  id_is_mul,
    input  logic                  id_is_jump,
    output logic                  stall,
    output logic                  bubble_ex,
    output logic                  hold_ex,
    output logic                  flush_if,
    output logic [1:0]            fwd_rs_sel,
    output logic [1:0]            fwd_rt_sel,
    output logic                  mul_busy
);

    // Counter only needs to reach MUL_LATENCY-1.
    localparam int              CNT_W      = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic            MUL_MULTI  = (MUL_LATENCY > 1) ? 1'b1 : 1'b0;
    localparam logic            WB_CHECK   = (WB_BYPASS == 0) ? 1'b1 : 1'b0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic                  write;
        logic                  lw;
        logic                  mul;
    } slot_t;

    localparam slot_t BUBBLE = '{waddr: {REG_ADDR_W{1'b0}}, write: 1'b0, lw: 1'b0, mul: 1'b0};

    // A source hazards against a slot only if it is really read, the slot
    // really writes it, and it is not the hard-wired zero register.
    function automatic logic src_match(input logic                  uses,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input slot_t                 slot);
        return uses && slot.write && (slot.waddr == src) && (src != {REG_ADDR_W{1'b0}});
    endfunction

`ifdef HAZARD_FWD_EN
    // Youngest producer wins: EX result takes priority over MEM result.
    function automatic logic [1:0] fwd_pick(input logic ex_m, input logic mem_m);
        logic [1:0] sel;
        if (ex_m) begin
            sel = 2'b01;
        end else if (mem_m) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction
`endif

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s, rs_wb_s, rt_wb_s;
    logic             busy_s, haz_s, stall_s;
    logic [1:0]       fwd_rs_s, fwd_rt_s;
    logic             unused_s;

    // Scoreboard comparison and hazard / forwarding decision.
    always_comb begin
        rs_ex_s  = src_match(id_uses_rs, id_rs, ex_q);
        rt_ex_s  = src_match(id_uses_rt, id_rt, ex_q);
        rs_mem_s = src_match(id_uses_rs, id_rs, mem_q);
        rt_mem_s = src_match(id_uses_rt, id_rt, mem_q);
        rs_wb_s  = src_match(id_uses_rs, id_rs, wb_q);
        rt_wb_s  = src_match(id_uses_rt, id_rt, wb_q);
        busy_s   = (cnt_q != {CNT_W{1'b0}});
`ifdef HAZARD_FWD_EN
        // Loads and multi-cycle MULs cannot forward out of EX in time; any
        // EX match on a MUL (busy or its final cycle) therefore stalls.
        haz_s    = ((rs_ex_s | rt_ex_s) & (ex_q.lw | (ex_q.mul & MUL_MULTI)))
                 | (WB_CHECK & (rs_wb_s | rt_wb_s));
        fwd_rs_s = fwd_pick(rs_ex_s, rs_mem_s);
        fwd_rt_s = fwd_pick(rt_ex_s, rt_mem_s);
`else
        haz_s    = rs_ex_s | rt_ex_s | rs_mem_s | rt_mem_s
                 | (WB_CHECK & (rs_wb_s | rt_wb_s));
        fwd_rs_s = 2'b00;
        fwd_rt_s = 2'b00;
`endif
        stall_s  = busy_s | haz_s;
    end

    // Scoreboard advance and multiplier counter next state.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (busy_s) begin
            // MUL stays in EX; MEM receives a bubble each busy cycle.
            ex_d  = ex_q;
            mem_d = BUBBLE;
            wb_d  = mem_q;
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (haz_s) begin
                ex_d  = BUBBLE;
                cnt_d = cnt_q;
            end else begin
                ex_d = '{waddr: id_waddr, write: id_write, lw: id_is_lw, mul: id_is_mul};
                // A MUL entering EX (also straight after another MUL) reloads.
                if (id_is_mul && MUL_MULTI) begin
                    cnt_d = MUL_RELOAD;
                end else begin
                    cnt_d = cnt_q;
                end
            end
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted so that an ID-stage
    // jump cannot raise flush_if during reset. Selects are only meaningful
    // when the ID instruction actually issues.
    assign stall      = rst_n & stall_s;
    assign hold_ex    = rst_n & busy_s;
    assign mul_busy   = rst_n & busy_s;
    assign bubble_ex  = rst_n & haz_s & ~busy_s;
    assign flush_if   = rst_n & id_is_jump & ~stall_s;
    assign fwd_rs_sel = (rst_n & ~stall_s) ? fwd_rs_s : 2'b00;
    assign fwd_rt_sel = (rst_n & ~stall_s) ? fwd_rt_s : 2'b00;

    // The lw/mul flags of the WB slot are carried for completeness only.
    assign unused_s = ^{wb_q.lw, wb_q.mul};

endmodule
